// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide unit.
// Op encodings are also used by the Controller decode.
package md_pkg;

    typedef enum logic [3:0] {
        NONE  = 4'd0,
        MULT  = 4'd1,
        MULTU = 4'd2,
        DIV   = 4'd3,
        DIVU  = 4'd4,
        MFHI  = 4'd5,
        MFLO  = 4'd6,
        MTHI  = 4'd7,
        MTLO  = 4'd8
    } md_op_e;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } md_state_e;

    function automatic logic is_arith(input md_op_e op);
        return (op == MULT) || (op == MULTU) || (op == DIV) || (op == DIVU);
    endfunction

    function automatic int unsigned op_latency(
        input md_op_e      op,
        input int unsigned mult_lat,
        input int unsigned div_lat
    );
        return ((op == DIV) || (op == DIVU)) ? div_lat : mult_lat;
    endfunction

endpackage

// File: rtl/md_arith.sv
// Combinational multiply/divide datapath working on latched operands.
// Signed divide goes through magnitudes so MIN/-1 wraps to MIN without trapping.
module md_arith
    import md_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  md_op_e           op,
    output logic [WIDTH-1:0] hi_res,
    output logic [WIDTH-1:0] lo_res,
    output logic             div_zero
);

    logic signed [2*WIDTH-1:0] prod_s;
    logic [2*WIDTH-1:0]        prod_u;
    logic [WIDTH-1:0]          mag_a;
    logic [WIDTH-1:0]          mag_b;
    logic [WIDTH-1:0]          dvsr;
    logic [WIDTH-1:0]          quo;
    logic [WIDTH-1:0]          rem;
    logic                      sgn_a;
    logic                      sgn_b;

    assign prod_s = $signed({{WIDTH{a[WIDTH-1]}}, a})
                  * $signed({{WIDTH{b[WIDTH-1]}}, b});
    assign prod_u = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

    assign sgn_a    = (op == DIV) && a[WIDTH-1];
    assign sgn_b    = (op == DIV) && b[WIDTH-1];
    assign mag_a    = sgn_a ? -a : a;
    assign mag_b    = sgn_b ? -b : b;
    // Keep the divider defined on a zero divisor; the result is discarded.
    assign dvsr     = (b == '0) ? WIDTH'(1) : mag_b;
    assign quo      = mag_a / dvsr;
    assign rem      = mag_a % dvsr;
    assign div_zero = ((op == DIV) || (op == DIVU)) && (b == '0);

    always_comb begin
        hi_res = '0;
        lo_res = '0;
        case (op)
            MULT:  {hi_res, lo_res} = prod_s;
            MULTU: {hi_res, lo_res} = prod_u;
            DIV, DIVU: begin
                lo_res = (sgn_a ^ sgn_b) ? -quo : quo;
                hi_res = sgn_a ? -rem : rem;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/md_unit.sv
// E-stage multiply/divide unit: HI/LO registers, fixed-latency FSM,
// and mfhi/mflo/mthi/mtlo service.
module md_unit
    import md_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] srcA,
    input  logic [WIDTH-1:0] srcB,
    output logic             start,
    output logic             busy,
    output logic [WIDTH-1:0] rd_data,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int CW      = $clog2(MAX_LAT + 1);

    md_op_e           op_e;
    md_op_e           op_q;
    md_state_e        state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic [WIDTH-1:0] hi_res;
    logic [WIDTH-1:0] lo_res;
    logic             div_zero;
    logic             mv_ok;

    assign op_e  = md_op_e'(op);
    assign busy  = (state == BUSY);
    assign start = !reset && req_valid && is_arith(op_e) && !busy;
    assign mv_ok = req_valid && !busy;
    assign hi    = hi_q;
    assign lo    = lo_q;

    always_comb begin
        rd_data = '0;
        case (op_e)
            MFHI:    rd_data = hi_q;
            MFLO:    rd_data = lo_q;
            default: rd_data = '0;
        endcase
    end

    md_arith #(.WIDTH(WIDTH)) u_arith (
        .a        (a_q),
        .b        (b_q),
        .op       (op_q),
        .hi_res   (hi_res),
        .lo_res   (lo_res),
        .div_zero (div_zero)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            a_q   <= '0;
            b_q   <= '0;
            op_q  <= NONE;
            hi_q  <= '0;
            lo_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= BUSY;
                        a_q   <= srcA;
                        b_q   <= srcB;
                        op_q  <= op_e;
                        cnt   <= CW'(op_latency(op_e, MULT_LAT, DIV_LAT));
                    end else if (mv_ok && op_e == MTHI) begin
                        hi_q <= srcA;
                    end else if (mv_ok && op_e == MTLO) begin
                        lo_q <= srcA;
                    end
                end
                BUSY: begin
                    if (cnt == CW'(1)) begin
                        state <= IDLE;
                        cnt   <= '0;
                        // A zero divisor still burns the latency but leaves HI/LO alone.
                        if (!div_zero) begin
                            hi_q <= hi_res;
                            lo_q <= lo_res;
                        end
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
